// File: rtl/param_updown_counter_pkg.sv
// Shared types for the parametrised up/down counter slice.
package counter_pkg;
   typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;
   typedef enum logic {CNT_DOWN = 1'b0, CNT_UP  = 1'b1} cnt_dir_e;
endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the up/down counter; master drives controls, slave is the counter.
interface param_updown_counter_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
);
   logic              en;
   logic              up_down;
   logic [STEP_W-1:0] step;
   logic              sat_mode;
   logic              clear;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  count;
   logic              tc;
   logic              wrap;
   logic              ovf_sticky;

   modport master (
      output en, up_down, step, sat_mode, clear, load, load_val,
      input  count, tc, wrap, ovf_sticky
   );

   modport slave (
      input  en, up_down, step, sat_mode, clear, load, load_val,
      output count, tc, wrap, ovf_sticky
   );
endinterface

// File: rtl/param_updown_counter_next_calc.sv
// Combinational next count and boundary detect for one enabled step in either direction.
module counter_next_calc
   import counter_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
   parameter int          STEP_W    = 4
) (
   input  logic [WIDTH-1:0]  i_count,
   input  logic [STEP_W-1:0] i_step,
   input  cnt_dir_e          i_dir,
   input  cnt_mode_e         i_mode,
   output logic [WIDTH-1:0]  o_next,
   output logic              o_bnd
);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
   localparam logic [WIDTH:0]   MOD     = MAX_EXT + 1'b1;
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic [WIDTH:0]   w_cnt_ext;
   logic [WIDTH:0]   w_step_ext;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_up_wrap;
   logic [WIDTH-1:0] w_dn_diff;
   logic [WIDTH-1:0] w_dn_wrap;

   // One extra bit so an up-step past the top of a full-range counter is still visible.
   assign w_cnt_ext  = {1'b0, i_count};
   assign w_step_ext = (WIDTH+1)'(i_step);
   assign w_sum      = w_cnt_ext + w_step_ext;
   assign w_up_wrap  = WIDTH'(w_sum - MOD);
   assign w_dn_diff  = WIDTH'(w_cnt_ext - w_step_ext);
   assign w_dn_wrap  = WIDTH'(w_cnt_ext + MOD - w_step_ext);

   always_comb begin
      o_next = i_count;
      o_bnd  = 1'b0;
      if (i_dir == CNT_UP) begin
         if (w_sum <= MAX_EXT) begin
            o_next = w_sum[WIDTH-1:0];
         end else begin
            o_bnd  = 1'b1;
            o_next = (i_mode == CNT_SAT) ? MAX_VAL : w_up_wrap;
         end
      end else begin
         if (w_cnt_ext >= w_step_ext) begin
            o_next = w_dn_diff;
         end else begin
            o_bnd  = 1'b1;
            o_next = (i_mode == CNT_SAT) ? '0 : w_dn_wrap;
         end
      end
   end
endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: state registers, clear/load/enable priority and boundary flags.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
   parameter int          STEP_W    = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   param_updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_calc_next;
   logic             w_calc_bnd;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;
   logic             w_ovf_nxt;
   logic             w_tc_nxt;

   counter_next_calc #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .STEP_W    (STEP_W)
   ) u_next_calc (
      .i_count (r_count),
      .i_step  (bus.step),
      .i_dir   (cnt_dir_e'(bus.up_down)),
      .i_mode  (cnt_mode_e'(bus.sat_mode)),
      .o_next  (w_calc_next),
      .o_bnd   (w_calc_bnd)
   );

   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      w_ovf_nxt   = r_ovf;
      if (bus.clear) begin
         w_count_nxt = '0;
         w_ovf_nxt   = 1'b0;
      end else if (bus.load) begin
         w_count_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
      end else if (bus.en) begin
         w_count_nxt = w_calc_next;
         w_wrap_nxt  = w_calc_bnd;
         w_ovf_nxt   = r_ovf | w_calc_bnd;
      end
   end

   // Terminal count follows the new count and the direction sampled at the same edge.
   assign w_tc_nxt = bus.up_down ? (w_count_nxt == MAX_VAL) : (w_count_nxt == '0);

   always_ff @(posedge clk) begin
      if (rstn) begin
         r_count <= '0;
         r_wrap  <= 1'b0;
         r_ovf   <= 1'b0;
         r_tc    <= ~bus.up_down;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
         r_ovf   <= w_ovf_nxt;
         r_tc    <= w_tc_nxt;
      end
   end

   assign bus.count      = r_count;
   assign bus.tc         = r_tc;
   assign bus.wrap       = r_wrap;
   assign bus.ovf_sticky = r_ovf;
endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter (WIDTH=4, MAX_COUNT=9): directed scenarios plus random traffic against an arithmetic model.
module tb_param_updown_counter;
   localparam int W    = 4;
   localparam int MAXC = 9;
   localparam int SW   = 4;

   logic clk;
   logic rstn;
   int   n_vec;
   int   n_err;
   bit   chk_en;

   int m_cnt, m_tc, m_wrap, m_ovf;

   param_updown_counter_if #(.WIDTH(W), .STEP_W(SW)) cif ();

   param_updown_counter #(.WIDTH(W), .MAX_COUNT(MAXC), .STEP_W(SW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (cif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain integer arithmetic on the counting rules.
   always @(posedge clk) begin
      int s;
      if (rstn) begin
         m_cnt = 0; m_wrap = 0; m_ovf = 0;
      end else if (cif.clear) begin
         m_cnt = 0; m_wrap = 0; m_ovf = 0;
      end else if (cif.load) begin
         m_cnt  = (int'(cif.load_val) > MAXC) ? MAXC : int'(cif.load_val);
         m_wrap = 0;
      end else if (cif.en) begin
         assert (int'(cif.step) <= MAXC) else $error("illegal step %0d", cif.step);
         m_wrap = 0;
         if (cif.up_down) begin
            s = m_cnt + int'(cif.step);
            if (s > MAXC) begin
               m_wrap = 1; m_ovf = 1;
               m_cnt  = cif.sat_mode ? MAXC : s - (MAXC + 1);
            end else m_cnt = s;
         end else begin
            s = m_cnt - int'(cif.step);
            if (s < 0) begin
               m_wrap = 1; m_ovf = 1;
               m_cnt  = cif.sat_mode ? 0 : s + MAXC + 1;
            end else m_cnt = s;
         end
      end else begin
         m_wrap = 0;
      end
      m_tc = cif.up_down ? int'(m_cnt == MAXC) : int'(m_cnt == 0);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_vec++;
         if (int'(cif.count) != m_cnt || int'(cif.tc) != m_tc ||
             int'(cif.wrap) != m_wrap || int'(cif.ovf_sticky) != m_ovf) begin
            n_err++;
            $display("FAIL model t=%0t count=%0d tc=%0d wrap=%0d ovf=%0d expected count=%0d tc=%0d wrap=%0d ovf=%0d",
                     $time, cif.count, cif.tc, cif.wrap, cif.ovf_sticky, m_cnt, m_tc, m_wrap, m_ovf);
         end
      end
   end

   task automatic drive(input bit r, input bit cl, input bit ld, input bit e,
                        input bit ud, input bit sm, input int st, input int lv);
      @(negedge clk);
      rstn         = r;
      cif.clear    = cl;
      cif.load     = ld;
      cif.en       = e;
      cif.up_down  = ud;
      cif.sat_mode = sm;
      cif.step     = SW'(st);
      cif.load_val = W'(lv);
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string nm, input int c, input int tc, input int w, input int o);
      n_vec++;
      if (int'(cif.count) != c || int'(cif.tc) != tc || int'(cif.wrap) != w || int'(cif.ovf_sticky) != o) begin
         n_err++;
         $display("FAIL %s: got count=%0d tc=%0d wrap=%0d ovf=%0d, want count=%0d tc=%0d wrap=%0d ovf=%0d",
                  nm, cif.count, cif.tc, cif.wrap, cif.ovf_sticky, c, tc, w, o);
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; chk_en = 0;
      rstn = 1'b1;
      cif.clear = 0; cif.load = 0; cif.en = 0; cif.up_down = 1;
      cif.sat_mode = 0; cif.step = '0; cif.load_val = '0;

      // reset, counting up
      drive(1, 0, 0, 0, 1, 0, 1, 0);
      chk_en = 1;
      lit("reset_up", 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) drive(0, 0, 0, 1, 1, 0, 1, 0);
      lit("up_at_9", 9, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 1, 0);
      lit("up_wrap_9_0", 0, 0, 1, 1);
      drive(0, 0, 0, 1, 1, 0, 1, 0);
      lit("up_after_wrap", 1, 0, 0, 1);

      // counting down from 0
      drive(0, 1, 0, 0, 0, 0, 1, 0);
      lit("clear_down_tc", 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 1, 0);
      lit("down_wrap_0_9", 9, 0, 1, 1);
      drive(0, 0, 0, 1, 0, 0, 1, 0);
      lit("down_8", 8, 0, 0, 1);

      // step 3 wrap from load 8
      drive(0, 1, 0, 0, 1, 0, 3, 0);
      drive(0, 0, 1, 0, 1, 0, 3, 8);
      lit("load_8", 8, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 3, 0);
      lit("step3_1", 1, 0, 1, 1);
      drive(0, 0, 0, 1, 1, 0, 3, 0);
      lit("step3_4", 4, 0, 0, 1);
      drive(0, 0, 0, 1, 1, 0, 3, 0);
      lit("step3_7", 7, 0, 0, 1);
      drive(0, 0, 0, 1, 1, 0, 3, 0);
      lit("step3_0", 0, 0, 1, 1);

      // saturate
      drive(0, 0, 1, 0, 1, 1, 4, 7);
      drive(0, 0, 0, 1, 1, 1, 4, 0);
      lit("sat_9", 9, 1, 1, 1);
      drive(0, 0, 0, 1, 1, 1, 4, 0);
      lit("sat_hold", 9, 1, 1, 1);
      drive(0, 0, 0, 1, 0, 1, 4, 0);
      lit("sat_down_5", 5, 0, 0, 1);
      drive(0, 0, 0, 1, 0, 1, 0, 0);
      lit("step0_hold", 5, 0, 0, 1);

      // load clamp and priorities
      drive(0, 0, 1, 0, 1, 0, 1, 15);
      lit("load_clamp", 9, 1, 0, 1);
      drive(0, 0, 1, 1, 1, 0, 1, 2);
      lit("load_over_en", 2, 0, 0, 1);
      drive(0, 1, 1, 1, 1, 0, 1, 5);
      lit("clear_over_load", 0, 0, 0, 0);

      // reset mid-count, then hold
      drive(0, 0, 1, 0, 1, 0, 1, 5);
      drive(0, 0, 0, 1, 1, 0, 5, 0);
      lit("to_wrap_0", 0, 0, 1, 1);
      drive(0, 0, 1, 0, 1, 0, 1, 5);
      drive(0, 0, 0, 1, 1, 0, 1, 0);
      lit("at_6", 6, 0, 0, 1);
      drive(1, 0, 0, 1, 1, 0, 1, 0);
      lit("reset_mid", 0, 0, 0, 0);
      drive(0, 0, 1, 0, 1, 0, 1, 4);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 3, 0);
      lit("en0_hold", 4, 0, 0, 0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 64) == 0, ($urandom % 40) == 0, ($urandom % 12) == 0,
               ($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 3) == 0,
               int'($urandom_range(0, MAXC)), int'($urandom_range(0, 15)));
      end

      @(negedge clk);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous up/down counter, successor to the fixed 4-bit up/down counter. Adds configurable width and modulus, a programmable step, a runtime wrap/saturate mode, clear, parallel load, a count enable and boundary event flags. Used as a general-purpose timer/index counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (>= 2)
MAX_COUNT, 2**WIDTH-1, terminal value; count range 0..MAX_COUNT (must be <= 2**WIDTH-1)
STEP_W, 4, width of the step input

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous, active-high reset (port keeps the codebase name; asserted = 1)
en  in  1  count enable
up_down  in  1  1 = count up, 0 = count down
step  in  STEP_W  increment/decrement amount per enabled cycle
sat_mode  in  1  0 = wrap modulo MAX_COUNT+1, 1 = saturate at 0 / MAX_COUNT
clear  in  1  synchronous clear to 0
load  in  1  synchronous parallel load
load_val  in  WIDTH  value for load
count  out  WIDTH  current count
tc  out  1  registered; 1 while count == MAX_COUNT (up) or count == 0 (down)
wrap  out  1  registered one-cycle pulse: the update just performed crossed a boundary (wrapped or saturated)
ovf_sticky  out  1  sticky: set on any wrap pulse, cleared by clear or reset

Behaviour:
- Reset (rstn=1 at clk edge): count=0, wrap=0, ovf_sticky=0; tc=0 if up_down=1 else 1 (combinational from registered count and current up_down is not allowed; tc is registered from next state).
- Priority per edge: rstn > clear > load > en. Lower-priority inputs are ignored that cycle.
- clear: count=0, wrap=0, ovf_sticky=0.
- load: count = min(load_val, MAX_COUNT); wrap=0; ovf_sticky unchanged.
- en=0 (no clear/load): count holds, wrap=0.
- en=1, up: sum = count + step computed in WIDTH+1 bits (step zero-extended). sum <= MAX_COUNT -> count=sum, wrap=0. Else wrap=1, ovf_sticky=1; sat_mode=0 -> count = sum - (MAX_COUNT+1); sat_mode=1 -> count = MAX_COUNT.
- en=1, down: count >= step -> count -= step, wrap=0. Else wrap=1, ovf_sticky=1; sat_mode=0 -> count = count + MAX_COUNT+1 - step; sat_mode=1 -> count = 0.
- step=0 with en=1: count holds, wrap=0.
- step > MAX_COUNT is illegal; behaviour unspecified, bench asserts it never occurs.
- Saturated at boundary and stepping further in sat_mode: count holds, wrap=1 every enabled cycle.
- tc updates in the same edge as count, from the new count and the sampled up_down; latency 1 cycle from any input to all outputs.
- Direction or mode change takes effect on the next enabled edge; no pipeline, no stale state.
- Reset or clear mid-count: takes effect at that edge regardless of en/load.

Decomposition:
- Package counter_pkg: typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e; typedef enum logic {CNT_DOWN, CNT_UP} cnt_dir_e.
- One sub-module natural: counter_next_calc (combinational next-value and boundary-detect from count, step, dir, mode, MAX_COUNT); top holds registers, priority mux and flags.

Test Plan:
- WIDTH=4, MAX_COUNT=9, step=1, up, wrap mode, en=1 from reset -> count 0,1,...,9,0; wrap pulses once on 9->0; tc=1 while count==9; ovf_sticky=1 after the wrap.
- Same config, down from 0 -> count 9,8,...; wrap pulse on 0->9; tc=1 at count 0.
- step=3, up, wrap, load_val=8 then en -> 8,1 (wrap=1),4,7,0 (wrap=1).
- step=4, up, sat_mode=1 from 7 -> 9 with wrap=1, then holds at 9 with wrap=1 each enabled cycle; switch to down -> 5, wrap=0.
- load_val=15 with MAX_COUNT=9 -> count=9; load and en together -> load wins; clear with load -> count=0, ovf_sticky=0.
- rstn=1 asserted mid-count at count=6 with en=1 -> count=0, wrap=0, ovf_sticky=0 at that edge; en=0 for 5 cycles -> count holds.
